clk_div: RTL and testbench
==========================

Name: clk_div

Overview:
- Programmable integer clock divider producing a 50%-duty square wave `hzX` from the system clock `clk`.
- Period = 2*(lim+1) clk cycles. Examples: lim=3 gives divide-by-8; lim=4 gives divide-by-10; lim=12 gives divide-by-26.
- Used to derive slow enable/tick clocks (e.g. 100 Hz down to ~4–12 Hz) for display/blink logic.
- `lim` is a run-time input, so one module serves every rate.

Parameters:
- WIDTH, 8, bit width of `lim` and of the internal counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- lim  input  WIDTH  half-period terminal count; `hzX` toggles every lim+1 clk cycles.
- hzX  output  1  divided clock, registered output.

Behaviour:
- State:
  - cnt: WIDTH-bit counter.
  - hzX: registered output bit.
- Reset:
  - rst=0 asynchronously forces cnt=0 and hzX=0, regardless of clk.
  - Both hold at 0 while rst=0.
- Counting, on each rising clk edge with rst=1:
  - if cnt >= lim: cnt <= 0 and hzX <= ~hzX.
  - else: cnt <= cnt+1, hzX unchanged.
- Latency after reset release:
  - First rising edge of hzX occurs on the (lim+1)-th rising clk edge after rst goes high.
  - hzX then toggles every lim+1 edges.
- Duty cycle:
  - Exactly 50%: high lim+1 cycles, low lim+1 cycles.
  - Odd total division ratios are not supported.
- lim=0: hzX toggles on every clk edge (divide-by-2).
- lim=2^WIDTH-1: cnt reaches the maximum value and wraps to 0 via the terminal compare, never by arithmetic overflow. Period = 2^(WIDTH+1) cycles.
- lim changes mid-count:
  - Sampled every cycle; no shadow register.
  - If new lim > cnt: counting continues to the new limit.
  - If new lim <= cnt: the `>=` compare fires on the next edge, so cnt <= 0 and hzX toggles. No runaway count to wrap.
- Reset asserted mid-period: immediate return to cnt=0, hzX=0. The sequence restarts from the top on release.
- hzX is a plain register output, with no combinational path from lim or rst release.
- hzX is intended as a logic-rate signal, not for clock-tree use.

Optional Feature:
- Macro: CLKDIV_TICK_EN.
- With CLKDIV_TICK_EN defined:
  - Adds output port `tick` (1 bit).
  - `tick` is a registered one-cycle pulse, high during the clk cycle immediately following each hzX toggle. It is therefore coincident with every hzX edge, rising and falling.
  - `tick` resets to 0 asynchronously with rst.
- Without CLKDIV_TICK_EN: port and logic are absent; hzX behaviour is identical in both builds.

Test Plan:
- Reset hold: rst=0 for 2 cycles with lim=4 -> cnt=0 and hzX=0 throughout. Asserting rst between edges clears hzX immediately.
- Divide-by-10: lim=4, release rst:
  - hzX rises on the 5th clk edge after release, falls on the 10th, rises on the 15th.
  - Period 10 cycles, high 5 cycles.
- Three instances in parallel, 1000 cycles from a common reset:
  - lim=3 -> period 8 cycles.
  - lim=12 -> period 26 cycles.
  - Measured edge spacing is constant for the whole run.
- Boundary lims:
  - lim=0 -> hzX toggles every edge.
  - lim=255 -> hzX toggles every 256 edges. cnt observed reaching 255 and returning to 0.
- Live lim change:
  - lim=12, wait until cnt=8, set lim=4 -> next edge cnt=0 and hzX toggles.
  - Subsequent toggles every 5 edges.
- With CLKDIV_TICK_EN defined, lim=3 -> `tick` is high for exactly 1 cycle every 4 cycles, aligned to the cycle after each hzX transition. `tick` is 0 during reset.

Source files
------------

// File: rtl/clk_div_if.sv
// Signal bundle for clk_div: run-time limit in, divided clock and counter view out.
// Optional `tick` pulse exists only when CLKDIV_TICK_EN is defined.
interface clk_div_if #(
    parameter int WIDTH = 8
);
    // No handshake: lim is a level input sampled on every rising clk edge, and
    // hzX/cnt/tick are registered levels valid for the whole cycle after that edge.
    logic [WIDTH-1:0] lim;
    logic             hzX;
    logic [WIDTH-1:0] cnt;
`ifdef CLKDIV_TICK_EN
    logic             tick;

    modport master (output lim, input hzX, input cnt, input tick);
    modport slave  (input lim, output hzX, output cnt, output tick);
`else
    modport master (output lim, input hzX, input cnt);
    modport slave  (input lim, output hzX, output cnt);
`endif
endinterface

// File: rtl/clk_div.sv
// Programmable 50%-duty clock divider: hzX toggles every lim+1 clk edges (period 2*(lim+1)).
// Optional feature macro CLKDIV_TICK_EN adds a one-cycle `tick` pulse after every hzX toggle.
module clk_div #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    clk_div_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             hz_q;
    logic             hz_d;
    logic             terminal;

    // The >= compare (not ==) makes a lim lowered below the current count
    // terminate on the next edge instead of running on to an arithmetic wrap.
    always_comb begin
        terminal = 1'b0;
        cnt_d    = cnt_q;
        hz_d     = hz_q;
        if (cnt_q >= bus.lim) begin
            terminal = 1'b1;
            cnt_d    = '0;
            hz_d     = ~hz_q;
        end else begin
            cnt_d    = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            hz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hz_q  <= hz_d;
        end
    end

    assign bus.hzX = hz_q;
    assign bus.cnt = cnt_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    // Registered from the same terminal condition, so it rises on the very edge hzX toggles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= terminal;
        end
    end

    assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: per-cycle scoreboard against a behavioural model,
// plus edge-spacing monitors on two parallel instances sharing the reset.
module tb_clk_div;

    logic clk;
    logic rst;

    clk_div_if #(.WIDTH(8)) bus0 ();
    clk_div_if #(.WIDTH(8)) bus1 ();
    clk_div_if #(.WIDTH(8)) bus2 ();

    clk_div #(.WIDTH(8)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    clk_div #(.WIDTH(8)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    clk_div #(.WIDTH(8)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Model state: edges counted since the last toggle, output level, and
    // whether the most recent edge toggled the output.
    int   m_since = 0;
    logic m_hz    = 1'b0;
    logic m_tick  = 1'b0;

    // Expected {tick, hzX, cnt} after each rising edge.
    logic [9:0] exp_q[$];

    // ---------------- driver ----------------
    // Drive lim/rst between edges, then push what the next rising edge must produce.
    task automatic step(input logic [7:0] l, input logic r);
        @(negedge clk);
        #2;
        bus0.lim = l;
        rst      = r;
        if (!r) begin
            m_since = 0;
            m_hz    = 1'b0;
            m_tick  = 1'b0;
            #1;
            checks++;
            if (bus0.hzX !== 1'b0 || bus0.cnt !== 8'd0) begin
                failures++;
                $display("FAIL async_reset: hzX=%0b cnt=%0d, required hzX=0 cnt=0", bus0.hzX, bus0.cnt);
            end
        end else if (m_since >= int'(l)) begin
            m_since = 0;
            m_hz    = ~m_hz;
            m_tick  = 1'b1;
        end else begin
            m_since = m_since + 1;
            m_tick  = 1'b0;
        end
        exp_q.push_back({m_tick, m_hz, 8'(m_since)});
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [9:0] exp_v;
    logic [7:0] prev_cnt  = 8'd0;
    logic       max_seen  = 1'b0;
    logic       wrap_seen = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus0.hzX !== exp_v[8]) begin
                failures++;
                $display("FAIL hzX @%0t: got %0b required %0b", $time, bus0.hzX, exp_v[8]);
            end
            checks++;
            if (bus0.cnt !== exp_v[7:0]) begin
                failures++;
                $display("FAIL cnt @%0t: got %0d required %0d", $time, bus0.cnt, exp_v[7:0]);
            end
`ifdef CLKDIV_TICK_EN
            checks++;
            if (bus0.tick !== exp_v[9]) begin
                failures++;
                $display("FAIL tick @%0t: got %0b required %0b", $time, bus0.tick, exp_v[9]);
            end
`endif
            if (bus0.cnt == 8'd255) max_seen = 1'b1;
            if (prev_cnt == 8'd255 && bus0.cnt == 8'd0) wrap_seen = 1'b1;
            prev_cnt = bus0.cnt;
        end
    end

    // ---------------- parallel edge-spacing monitor ----------------
    // The k-th transition of an instance with limit L must land exactly L+1 edges apart.
    logic par_en = 1'b0;
    int   cyc_par = 0;
    int   edges1 = 0;
    int   edges2 = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always @(negedge clk) begin
        if (par_en) begin
            cyc_par++;
            if (bus1.hzX !== prev1) begin
                edges1++;
                checks++;
                if (cyc_par != 4 * edges1) begin
                    failures++;
                    $display("FAIL par_lim3_edge: edge %0d at cycle %0d, required cycle %0d", edges1, cyc_par, 4 * edges1);
                end
                prev1 = bus1.hzX;
            end
            if (bus2.hzX !== prev2) begin
                edges2++;
                checks++;
                if (cyc_par != 13 * edges2) begin
                    failures++;
                    $display("FAIL par_lim12_edge: edge %0d at cycle %0d, required cycle %0d", edges2, cyc_par, 13 * edges2);
                end
                prev2 = bus2.hzX;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] rnd_lim;
    logic       hit;

    initial begin
        rst      = 1'b0;
        bus0.lim = 8'd4;
        bus1.lim = 8'd3;
        bus2.lim = 8'd12;

        // Reset hold, then divide-by-10 on u0 alongside lim=3 / lim=12 for 1000 cycles.
        step(8'd4, 1'b0);
        step(8'd4, 1'b0);
        step(8'd4, 1'b1);
        par_en  = 1'b1;
        cyc_par = 0;
        repeat (999) step(8'd4, 1'b1);
        @(negedge clk);
        #1;
        par_en = 1'b0;
        checks++;
        if (edges1 != 250) begin
            failures++;
            $display("FAIL par_lim3_count: got %0d edges required 250", edges1);
        end
        checks++;
        if (edges2 != 76) begin
            failures++;
            $display("FAIL par_lim12_count: got %0d edges required 76", edges2);
        end

        // lim=0: divide-by-2.
        step(8'd0, 1'b0);
        repeat (12) step(8'd0, 1'b1);

        // lim=255: full-range count, terminal compare does the wrap.
        step(8'd255, 1'b0);
        repeat (600) step(8'd255, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (max_seen !== 1'b1) begin
            failures++;
            $display("FAIL max_cnt: reached255=%0b required 1", max_seen);
        end
        checks++;
        if (wrap_seen !== 1'b1) begin
            failures++;
            $display("FAIL wrap_cnt: wrapped=%0b required 1", wrap_seen);
        end

        // Live change: lim=12 until cnt=8, then lim=4 forces terminal on the next edge.
        step(8'd12, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(8'd12, 1'b1);
            if (m_since == 8) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL live_reach8: model cnt=%0d required 8", m_since);
        end
        repeat (20) step(8'd4, 1'b1);

        // Randomized lim changes with occasional mid-period resets.
        rnd_lim = 8'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rnd_lim = 8'($urandom_range(0, 15));
            step(rnd_lim, ($urandom_range(0, 39) != 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
